// File: rtl/myfilter_pkg.sv
// myfilter_pkg: shared datapath command format and sequencer state encoding
package myfilter_pkg;
  localparam int DP_NTAPS = 5;
  localparam int DP_TAPBITS = $clog2(DP_NTAPS);
  typedef enum logic [1:0] {DMEM_READ, DMEM_SHIFT, DMEM_CLEAR} dmem_cmd_t;
  typedef enum logic [1:0] {ALU_NOP, ALU_MU, ALU_ADMU, ALU_SATA} alu_cmd_t;
  typedef enum logic [1:0] {ACC_NOP, ACC_LOAD, ACC_CLEAR} acc_cmd_t;
  typedef struct packed {
    logic [DP_TAPBITS-1:0] cmem_addr;
    dmem_cmd_t             dmem_cmd;
    logic [DP_TAPBITS-1:0] dmem_addr;
    alu_cmd_t              alu_cmd;
    acc_cmd_t              acc_cmd;
    logic                  extvalid;
  } dp_cmd_t;
  localparam int CMDBITS = $bits(dp_cmd_t);
  typedef enum logic [2:0] {STOPPED, PROGRAM, CLEAR, EXTIN, SHIFT, TAP, SAT, EXTOUT} dpc_fsm_t;
  localparam dp_cmd_t CMD_NOP = '0;
  localparam dp_cmd_t CMD_CLR = '{cmem_addr: '0, dmem_cmd: DMEM_CLEAR, dmem_addr: '0,
                                  alu_cmd: ALU_NOP, acc_cmd: ACC_CLEAR, extvalid: 1'b0};
  localparam dp_cmd_t CMD_SHIFT = '{cmem_addr: '0, dmem_cmd: DMEM_SHIFT, dmem_addr: '0,
                                    alu_cmd: ALU_NOP, acc_cmd: ACC_NOP, extvalid: 1'b0};
  localparam dp_cmd_t CMD_SAT = '{cmem_addr: '0, dmem_cmd: DMEM_READ, dmem_addr: '0,
                                  alu_cmd: ALU_SATA, acc_cmd: ACC_LOAD, extvalid: 1'b0};
endpackage

// File: rtl/fir_tap_counter.sv
// fir_tap_counter: tap index register with terminal-count flag against the active tap count
module fir_tap_counter #(
  parameter int TAPBITS = 3,
  parameter int CNTBITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [CNTBITS-1:0] n,
  output logic [TAPBITS-1:0] k,
  output logic               last
);
  always_ff @(posedge clk)
    if (rst || clr) k <= '0;
    else if (inc) k <= k + 1'b1;
  assign last = CNTBITS'(k) == n - CNTBITS'(1);
endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: Moore controller emitting one datapath command per cycle over a runtime tap count
module fir_sequencer
  import myfilter_pkg::*;
#(
  parameter int NTAPS   = DP_NTAPS,
  parameter int TAPBITS = $clog2(NTAPS),
  parameter int CNTBITS = $clog2(NTAPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic               program_in,
  input  logic [CNTBITS-1:0] ntaps_in,
  input  logic               extvalid_in,
  output logic [CMDBITS-1:0] dp_cmd_out,
  output logic               busy_out,
  output logic               overrun_out
);
  dpc_fsm_t state, state_d;
  logic [CNTBITS-1:0] n, n_d;
  logic [TAPBITS-1:0] k;
  logic last;
  dp_cmd_t cmd;
  assign n_d = (ntaps_in == '0 || ntaps_in > CNTBITS'(NTAPS)) ? CNTBITS'(NTAPS) : ntaps_in;
  fir_tap_counter #(.TAPBITS(TAPBITS), .CNTBITS(CNTBITS)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == SHIFT),
    .inc (state == TAP && !last),
    .n   (n),
    .k   (k),
    .last(last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state       <= STOPPED;
      n           <= CNTBITS'(NTAPS);
      overrun_out <= 1'b0;
    end else begin
      state <= state_d;
      if (state == CLEAR) begin
        n           <= n_d;
        overrun_out <= 1'b0;
      end else if (extvalid_in && busy_out) overrun_out <= 1'b1;
    end
  always_comb begin
    state_d = STOPPED;
    case (state)
      STOPPED: state_d = program_in ? PROGRAM : start_in ? CLEAR : STOPPED;
      PROGRAM: state_d = program_in ? PROGRAM : STOPPED;
      CLEAR:   state_d = EXTIN;
      EXTIN:   state_d = !start_in ? STOPPED : extvalid_in ? SHIFT : EXTIN;
      SHIFT:   state_d = TAP;
      TAP:     state_d = last ? SAT : TAP;
      SAT:     state_d = EXTOUT;
      EXTOUT:  state_d = EXTIN;
      default: state_d = STOPPED;
    endcase
  end
  always_comb begin
    cmd = CMD_NOP;
    case (state)
      CLEAR:  cmd = CMD_CLR;
      SHIFT:  cmd = CMD_SHIFT;
      SAT:    cmd = CMD_SAT;
      EXTOUT: cmd.extvalid = 1'b1;
      TAP: begin
        cmd.cmem_addr = k;
        cmd.dmem_addr = k;
        cmd.alu_cmd   = (k == '0) ? ALU_MU : ALU_ADMU;
        cmd.acc_cmd   = ACC_LOAD;
      end
      default: cmd = CMD_NOP;
    endcase
  end
  assign dp_cmd_out = cmd;
  assign busy_out   = state inside {CLEAR, SHIFT, TAP, SAT, EXTOUT};
endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed stimulus with a cycle-stamped command scoreboard
module tb_fir_sequencer;
  import myfilter_pkg::*;
  localparam int NTAPS = DP_NTAPS;
  localparam int CNTBITS = $clog2(NTAPS + 1);
  logic clk = 1'b0, rst = 1'b1, start_in = 1'b0, program_in = 1'b0, extvalid_in = 1'b0;
  logic [CNTBITS-1:0] ntaps_in = CNTBITS'(NTAPS);
  logic [CMDBITS-1:0] dp_cmd_out;
  logic busy_out, overrun_out;
  int cyc = 0, total = 0, bad = 0, e;
  typedef struct {
    dp_cmd_t cmd;
    int      at;
  } exp_t;
  exp_t q[$];
  exp_t mx;

  fir_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .program_in (program_in),
    .ntaps_in   (ntaps_in),
    .extvalid_in(extvalid_in),
    .dp_cmd_out (dp_cmd_out),
    .busy_out   (busy_out),
    .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic dp_cmd_t tap_cmd(int k);
    dp_cmd_t c = '0;
    c.cmem_addr = DP_TAPBITS'(k);
    c.dmem_addr = DP_TAPBITS'(k);
    c.alu_cmd   = (k == 0) ? ALU_MU : ALU_ADMU;
    c.acc_cmd   = ACC_LOAD;
    return c;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(dp_cmd_t c, int at);
    q.push_back('{c, at});
  endtask

  // expected commands for a frame accepted at edge e: SHIFT, n taps, SAT, EXTOUT
  task automatic frame(int n, int at, int cnt);
    dp_cmd_t c;
    for (int j = 0; j < n + 3 && j < cnt; j++) begin
      if (j == 0) c = CMD_SHIFT;
      else if (j <= n) c = tap_cmd(j - 1);
      else if (j == n + 1) c = CMD_SAT;
      else begin
        c = CMD_NOP;
        c.extvalid = 1'b1;
      end
      push(c, at + j);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic sample(int n);
    extvalid_in = 1'b1;
    frame(n, cyc + 1, n + 3);
    step();
    extvalid_in = 1'b0;
    repeat (n + 3) step();
  endtask

  task automatic restart(int nt);
    start_in = 1'b0;
    step();
    ntaps_in = CNTBITS'(nt);
    start_in = 1'b1;
    push(CMD_CLR, cyc + 1);
    step();
    step();
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].at < cyc) begin
      total++;
      bad++;
      $display("FAIL missing cmd: expected %h at cycle %0d, not observed by cycle %0d", q[0].cmd, q[0].at, cyc);
      void'(q.pop_front());
    end
    if (dp_cmd_out != '0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected cmd: got %h at cycle %0d, expected none", dp_cmd_out, cyc);
      end else begin
        mx = q.pop_front();
        if (dp_cmd_out !== mx.cmd || cyc != mx.at) begin
          bad++;
          $display("FAIL cmd: got %h at cycle %0d expected %h at cycle %0d", dp_cmd_out, cyc, mx.cmd, mx.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    step();
    step();
    check("reset cmd", dp_cmd_out, 0);
    check("reset busy", busy_out, 0);
    check("reset overrun", overrun_out, 0);
    rst = 1'b0;
    ntaps_in = 5;
    start_in = 1'b1;
    push(CMD_CLR, cyc + 1);
    step();
    check("busy in CLEAR", busy_out, 1);
    step();
    check("busy in EXTIN", busy_out, 0);
    sample(5);
    sample(5);
    check("no overrun at min spacing", overrun_out, 0);
    extvalid_in = 1'b1;
    e = cyc + 1;
    frame(5, e, 8);
    step();
    extvalid_in = 1'b0;
    repeat (7) step();
    check("busy in EXTOUT", busy_out, 1);
    extvalid_in = 1'b1;
    step();
    extvalid_in = 1'b0;
    check("overrun from EXTOUT sample", overrun_out, 1);
    repeat (4) step();
    check("EXTOUT sample dropped", busy_out, 0);
    restart(0);
    check("overrun cleared by CLEAR", overrun_out, 0);
    sample(5);
    restart(7);
    sample(5);
    restart(6);
    sample(5);
    restart(2);
    ntaps_in = 4;
    sample(2);
    sample(2);
    restart(5);
    extvalid_in = 1'b1;
    e = cyc + 1;
    frame(5, e, 8);
    step();
    extvalid_in = 1'b0;
    step();
    step();
    extvalid_in = 1'b1;
    step();
    extvalid_in = 1'b0;
    check("overrun in TAP k=1", overrun_out, 1);
    repeat (5) step();
    check("overrun sticky", overrun_out, 1);
    sample(5);
    check("overrun sticky after frame", overrun_out, 1);
    start_in = 1'b0;
    step();
    check("overrun held in STOPPED", overrun_out, 1);
    program_in = 1'b1;
    start_in = 1'b1;
    step();
    check("busy in PROGRAM", busy_out, 0);
    step();
    step();
    program_in = 1'b0;
    push(CMD_CLR, cyc + 2);
    step();
    check("busy after PROGRAM exit", busy_out, 0);
    step();
    check("busy in CLEAR after PROGRAM", busy_out, 1);
    step();
    check("overrun cleared after PROGRAM", overrun_out, 0);
    program_in = 1'b1;
    sample(5);
    program_in = 1'b0;
    extvalid_in = 1'b1;
    e = cyc + 1;
    frame(5, e, 8);
    step();
    extvalid_in = 1'b0;
    step();
    step();
    start_in = 1'b0;
    repeat (5) step();
    extvalid_in = 1'b1;
    step();
    extvalid_in = 1'b0;
    check("overrun in EXTOUT after stop", overrun_out, 1);
    step();
    check("busy after stop", busy_out, 0);
    extvalid_in = 1'b1;
    repeat (2) step();
    extvalid_in = 1'b0;
    repeat (2) step();
    restart(5);
    extvalid_in = 1'b1;
    e = cyc + 1;
    frame(5, e, 4);
    step();
    extvalid_in = 1'b0;
    step();
    extvalid_in = 1'b1;
    step();
    extvalid_in = 1'b0;
    step();
    check("overrun before reset", overrun_out, 1);
    rst = 1'b1;
    start_in = 1'b0;
    step();
    check("mid-TAP reset cmd", dp_cmd_out, 0);
    check("mid-TAP reset busy", busy_out, 0);
    check("mid-TAP reset overrun", overrun_out, 0);
    rst = 1'b0;
    repeat (3) step();
    check("scoreboard drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
